// File: rtl/kgp_control_fsm.sv
// -----------------------------------------------------------------------------
// kgp_control_fsm
//
// Multi-cycle main controller for the KGP_RISC datapath. It walks each
// instruction through FETCH / DECODE / EXEC / MEM / WB and drives the per-cycle
// strobes for the PC, instruction register, ALU, data memory and register file.
// Data-memory accesses wait in MEM until memReady. It also keeps a counter of
// retired instructions and a terminal HALT state.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start      in   1      leave IDLE (ignored elsewhere)
//   opcode     in   6      instr[31:26], latched at the end of DECODE
//   zeroFlag   in   1      ALU zero flag   (used only in EXEC)
//   signFlag   in   1      ALU sign flag   (used only in EXEC)
//   carryFlag  in   1      ALU carry flag  (used only in EXEC)
//   memReady   in   1      data-memory completion (used only in MEM)
//   irWrite    out  1      load instruction register
//   pcWrite    out  1      update PC
//   pcSrc      out  2      00 PC+4, 01 target, 10 register rs
//   aluSrc     out  1      0 rt, 1 imm
//   aluOp      out  3      opReg[2:0] during EXEC, else 000
//   memRead    out  1      load request, held until memReady
//   memWrite   out  1      store request, held until memReady
//   regWrite   out  1      register-file write enable
//   memToReg   out  1      writeback from memory
//   link       out  1      write PC+4 into r31
//   halted     out  1      high in HALT
//   state      out  3      current state encoding
//   retired    out  CNT_W  completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module kgp_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             zeroFlag,
    input  logic             signFlag,
    input  logic             carryFlag,
    input  logic             memReady,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             aluSrc,
    output logic [2:0]       aluOp,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic             memToReg,
    output logic             link,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instruction classes, taken from opReg[5:3]
    localparam logic [2:0] CLS_REG   = 3'b000;
    localparam logic [2:0] CLS_IMM   = 3'b001;
    localparam logic [2:0] CLS_SHIFT = 3'b010;
    localparam logic [2:0] CLS_LOAD  = 3'b011;
    localparam logic [2:0] CLS_STORE = 3'b100;
    localparam logic [2:0] CLS_JUMP  = 3'b101;
    localparam logic [2:0] CLS_COND  = 3'b110;
    localparam logic [2:0] CLS_REGBR = 3'b111;

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       link;
        logic       halted;
    } strobes_t;

    // Strobe pattern for a state given the instruction it is working on.
    // The conditional-branch pcWrite is excluded: it depends on live flags.
    function automatic strobes_t strobes_for(input state_t st, input logic [5:0] op);
        strobes_t s;
        s = '0;
        case (st)
            ST_FETCH: begin
                s.ir_write = 1'b1;
                s.pc_write = 1'b1;
                s.pc_src   = 2'b00;
            end
            ST_EXEC: begin
                s.alu_op = op[2:0];
                case (op[5:3])
                    CLS_IMM, CLS_LOAD, CLS_STORE: s.alu_src = 1'b1;
                    CLS_JUMP: begin
                        s.pc_write  = 1'b1;
                        s.pc_src    = 2'b01;
                        s.reg_write = op[0];
                        s.link      = op[0];
                    end
                    CLS_COND:  s.pc_src = 2'b01;
                    CLS_REGBR: begin
                        s.pc_write = 1'b1;
                        s.pc_src   = 2'b10;
                    end
                    default:   s.alu_src = 1'b0;
                endcase
            end
            ST_MEM: begin
                s.mem_read  = (op[5:3] == CLS_LOAD);
                s.mem_write = (op[5:3] == CLS_STORE);
            end
            ST_WB: begin
                s.reg_write  = 1'b1;
                s.mem_to_reg = (op[5:3] == CLS_LOAD);
            end
            ST_HALT:  s.halted = 1'b1;
            default:  s = '0;
        endcase
        return s;
    endfunction

    // Branch condition selected by opReg[2:0]; codes 101-111 are never taken.
    function automatic logic cond_taken(input logic [2:0] sel, input logic z,
                                        input logic sg, input logic c);
        logic t;
        case (sel)
            3'b000:  t = sg;
            3'b001:  t = z;
            3'b010:  t = ~z;
            3'b011:  t = c;
            3'b100:  t = ~c;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [5:0]       op_r;
    logic [5:0]       op_next_s;
    strobes_t         strobe_r;
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;
    logic             cond_pc_write_s;

    // Next-state selection
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_HALT) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_r[5:3])
                    CLS_REG, CLS_IMM, CLS_SHIFT: next_state_s = ST_WB;
                    CLS_LOAD, CLS_STORE:         next_state_s = ST_MEM;
                    default:                     next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!memReady) begin
                    next_state_s = ST_MEM;
                end else if (op_r[5:3] == CLS_LOAD) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WB:   next_state_s = ST_FETCH;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Opcode capture point and retirement detection
    always_comb begin
        op_next_s = op_r;
        if (state_r == ST_DECODE) begin
            op_next_s = opcode;
        end else begin
            op_next_s = op_r;
        end
        // An instruction completes whenever control returns to FETCH from
        // a working state; the DECODE->HALT path never reaches here.
        retire_s = (next_state_s == ST_FETCH) &&
                   ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB));
    end

    // State, latched opcode, registered strobes and retirement counter.
    // Strobes are precomputed for the state being entered so that each output
    // is a clean flop while still reading as a function of state/opReg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_r      <= 6'd0;
            strobe_r  <= '0;
            retired_r <= '0;
        end else begin
            state_r  <= next_state_s;
            op_r     <= op_next_s;
            strobe_r <= strobes_for(next_state_s, op_next_s);
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Conditional-branch PC write follows the flags live in the EXEC cycle
    always_comb begin
        cond_pc_write_s = (state_r == ST_EXEC) && (op_r[5:3] == CLS_COND) &&
                          cond_taken(op_r[2:0], zeroFlag, signFlag, carryFlag);
    end

    assign irWrite  = strobe_r.ir_write;
    assign pcWrite  = strobe_r.pc_write | cond_pc_write_s;
    assign pcSrc    = strobe_r.pc_src;
    assign aluSrc   = strobe_r.alu_src;
    assign aluOp    = strobe_r.alu_op;
    assign memRead  = strobe_r.mem_read;
    assign memWrite = strobe_r.mem_write;
    assign regWrite = strobe_r.reg_write;
    assign memToReg = strobe_r.mem_to_reg;
    assign link     = strobe_r.link;
    assign halted   = strobe_r.halted;
    assign state    = state_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Testbench for kgp_control_fsm: a driver issues one directed vector per cycle
// and queues the outputs expected during that cycle; a monitor pops and
// compares on the falling edge.
module tb_kgp_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zeroFlag = 1'b0, signFlag = 1'b0, carryFlag = 1'b0;
    logic        memReady = 1'b0;
    logic        irWrite, pcWrite, aluSrc, memRead, memWrite;
    logic        regWrite, memToReg, link, halted;
    logic [1:0]  pcSrc;
    logic [2:0]  aluOp;
    logic [2:0]  state;
    logic [15:0] retired;

    kgp_control_fsm #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .zeroFlag(zeroFlag), .signFlag(signFlag), .carryFlag(carryFlag),
        .memReady(memReady), .irWrite(irWrite), .pcWrite(pcWrite),
        .pcSrc(pcSrc), .aluSrc(aluSrc), .aluOp(aluOp), .memRead(memRead),
        .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg),
        .link(link), .halted(halted), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Expected-output layout:
    // ir pw src[1:0] as aop[2:0] mr mw rw m2r lk h
    localparam logic [13:0] O_NONE  = 14'b0_0_00_0_000_0_0_0_0_0_0;
    localparam logic [13:0] O_FETCH = 14'b1_1_00_0_000_0_0_0_0_0_0;
    localparam logic [13:0] O_WBALU = 14'b0_0_00_0_000_0_0_1_0_0_0;
    localparam logic [13:0] O_EXLS  = 14'b0_0_00_1_000_0_0_0_0_0_0;
    localparam logic [13:0] O_MEMLD = 14'b0_0_00_0_000_1_0_0_0_0_0;
    localparam logic [13:0] O_MEMST = 14'b0_0_00_0_000_0_1_0_0_0_0;
    localparam logic [13:0] O_WBLD  = 14'b0_0_00_0_000_0_0_1_1_0_0;
    localparam logic [13:0] O_HALT  = 14'b0_0_00_0_000_0_0_0_0_0_1;

    typedef struct {
        int          step;
        logic [2:0]  st;
        logic [13:0] o;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   step_n = 0;
    logic [13:0] act_o;

    assign act_o = {irWrite, pcWrite, pcSrc, aluSrc, aluOp, memRead, memWrite,
                    regWrite, memToReg, link, halted};

    // Drive one cycle of inputs and queue the outputs expected in that cycle
    task automatic cyc(input logic r, input logic st, input logic [5:0] op,
                       input logic [2:0] flg, input logic mr,
                       input logic [2:0] es, input logic [13:0] eo,
                       input logic [15:0] eret);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r;
        start = st;
        opcode = op;
        {zeroFlag, signFlag, carryFlag} = flg;
        memReady = mr;
        step_n++;
        e.step = step_n;
        e.st = es;
        e.o = eo;
        e.ret = eret;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (state !== mon_e.st) begin
                failures++;
                $display("FAIL step%0d state act=%0d exp=%0d", mon_e.step, state, mon_e.st);
            end
            checks++;
            if (act_o !== mon_e.o) begin
                failures++;
                $display("FAIL step%0d strobes act=%b exp=%b", mon_e.step, act_o, mon_e.o);
            end
            checks++;
            if (retired !== mon_e.ret) begin
                failures++;
                $display("FAIL step%0d retired act=%0d exp=%0d", mon_e.step, retired, mon_e.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        cyc(1, 0, 6'b000011, 3'b000, 0, 3'd0, O_NONE, 16'd0);
        // reg ALU 000011: 1,2,3,5,1
        cyc(0, 1, 6'b000011, 3'b000, 0, 3'd0, O_NONE, 16'd0);
        cyc(0, 0, 6'b000011, 3'b000, 0, 3'd1, O_FETCH, 16'd0);
        cyc(0, 0, 6'b000011, 3'b000, 0, 3'd2, O_NONE, 16'd0);
        cyc(0, 0, 6'b000011, 3'b000, 0, 3'd3, 14'b0_0_00_0_011_0_0_0_0_0_0, 16'd0);
        cyc(0, 0, 6'b000011, 3'b000, 0, 3'd5, O_WBALU, 16'd0);
        // load 011000, three wait states, start held high throughout
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd1, O_FETCH, 16'd1);
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd2, O_NONE, 16'd1);
        cyc(0, 1, 6'b011000, 3'b111, 0, 3'd3, O_EXLS, 16'd1);
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd4, O_MEMLD, 16'd1);
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd4, O_MEMLD, 16'd1);
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd4, O_MEMLD, 16'd1);
        cyc(0, 1, 6'b011000, 3'b000, 1, 3'd4, O_MEMLD, 16'd1);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd5, O_WBLD, 16'd1);
        // store 100000, memReady immediately
        cyc(0, 0, 6'b100000, 3'b000, 0, 3'd1, O_FETCH, 16'd2);
        cyc(0, 0, 6'b100000, 3'b000, 0, 3'd2, O_NONE, 16'd2);
        cyc(0, 0, 6'b100000, 3'b000, 0, 3'd3, O_EXLS, 16'd2);
        cyc(0, 0, 6'b100000, 3'b000, 1, 3'd4, O_MEMST, 16'd2);
        // conditional 110001 (zero), taken
        cyc(0, 0, 6'b110001, 3'b000, 0, 3'd1, O_FETCH, 16'd3);
        cyc(0, 0, 6'b110001, 3'b100, 0, 3'd2, O_NONE, 16'd3);
        cyc(0, 0, 6'b110001, 3'b100, 0, 3'd3, 14'b0_1_01_0_001_0_0_0_0_0_0, 16'd3);
        // conditional 110001, zero high outside EXEC only: not taken
        cyc(0, 0, 6'b110001, 3'b100, 0, 3'd1, O_FETCH, 16'd4);
        cyc(0, 0, 6'b110001, 3'b100, 0, 3'd2, O_NONE, 16'd4);
        cyc(0, 0, 6'b110001, 3'b011, 0, 3'd3, 14'b0_0_01_0_001_0_0_0_0_0_0, 16'd4);
        // conditional 110100 (!carry), carry low in EXEC: taken
        cyc(0, 0, 6'b110100, 3'b001, 0, 3'd1, O_FETCH, 16'd5);
        cyc(0, 0, 6'b110100, 3'b001, 0, 3'd2, O_NONE, 16'd5);
        cyc(0, 0, 6'b110100, 3'b110, 0, 3'd3, 14'b0_1_01_0_100_0_0_0_0_0_0, 16'd5);
        // register branch 111010
        cyc(0, 0, 6'b111010, 3'b000, 0, 3'd1, O_FETCH, 16'd6);
        cyc(0, 0, 6'b111010, 3'b000, 0, 3'd2, O_NONE, 16'd6);
        cyc(0, 0, 6'b111010, 3'b000, 0, 3'd3, 14'b0_1_10_0_010_0_0_0_0_0_0, 16'd6);
        // conditional 110101: never taken even with all flags set
        cyc(0, 0, 6'b110101, 3'b000, 0, 3'd1, O_FETCH, 16'd7);
        cyc(0, 0, 6'b110101, 3'b000, 0, 3'd2, O_NONE, 16'd7);
        cyc(0, 0, 6'b110101, 3'b111, 0, 3'd3, 14'b0_0_01_0_101_0_0_0_0_0_0, 16'd7);
        // branch-and-link 101001
        cyc(0, 0, 6'b101001, 3'b000, 0, 3'd1, O_FETCH, 16'd8);
        cyc(0, 0, 6'b101001, 3'b000, 0, 3'd2, O_NONE, 16'd8);
        cyc(0, 0, 6'b101001, 3'b000, 0, 3'd3, 14'b0_1_01_0_001_0_0_1_0_1_0, 16'd8);
        // halt 111111, then 20 cycles with start toggling
        cyc(0, 0, 6'b111111, 3'b000, 0, 3'd1, O_FETCH, 16'd9);
        cyc(0, 0, 6'b111111, 3'b000, 0, 3'd2, O_NONE, 16'd9);
        for (int i = 0; i < 20; i++) begin
            cyc(0, i[0], 6'b111111, 3'b000, i[1], 3'd6, O_HALT, 16'd9);
        end
        // reset out of HALT, one ALU instruction, then reset during a MEM wait
        cyc(1, 0, 6'b000001, 3'b000, 0, 3'd6, O_HALT, 16'd9);
        cyc(0, 1, 6'b000001, 3'b000, 0, 3'd0, O_NONE, 16'd0);
        cyc(0, 0, 6'b000001, 3'b000, 0, 3'd1, O_FETCH, 16'd0);
        cyc(0, 0, 6'b000001, 3'b000, 0, 3'd2, O_NONE, 16'd0);
        cyc(0, 0, 6'b000001, 3'b000, 0, 3'd3, 14'b0_0_00_0_001_0_0_0_0_0_0, 16'd0);
        cyc(0, 0, 6'b000001, 3'b000, 0, 3'd5, O_WBALU, 16'd0);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd1, O_FETCH, 16'd1);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd2, O_NONE, 16'd1);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd3, O_EXLS, 16'd1);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd4, O_MEMLD, 16'd1);
        cyc(1, 0, 6'b011000, 3'b000, 0, 3'd4, O_MEMLD, 16'd1);
        cyc(0, 0, 6'b011000, 3'b000, 1, 3'd0, O_NONE, 16'd0);
        cyc(0, 1, 6'b011000, 3'b000, 0, 3'd0, O_NONE, 16'd0);
        cyc(0, 0, 6'b011000, 3'b000, 0, 3'd1, O_FETCH, 16'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
